// File: rtl/mdr_fetch_ctrl_pkg.sv
// Shared definitions for the MDR fetch sequencer: state encoding and default sizing.
package mdr_fetch_ctrl_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int NBYTES_DEF  = 2;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/mdr_fetch_if.sv
// Handshake bundle between the CPU control unit / memory and the MDR fetch sequencer.
interface mdr_fetch_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              mem_ack;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mdr_re;
  logic              mdr_shift;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  start, base_addr, mem_ack,
    output mem_rd, mem_addr, mdr_re, mdr_shift, busy, done, err
  );

  modport master (
    output start, base_addr, mem_ack,
    input  mem_rd, mem_addr, mdr_re, mdr_shift, busy, done, err
  );
endinterface

// File: rtl/mdr_wait_timer.sv
// Loadable down-counter guarding one memory request; expired when the budget is used up.
module mdr_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LOAD = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= LOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/mdr_fetch_ctrl.sv
// Byte-serial fill of the 15-bit MDR: NBYTES reads from consecutive addresses,
// first byte ends up most significant, with a per-request acknowledge timeout.
module mdr_fetch_ctrl
  import mdr_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NBYTES  = NBYTES_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic        clk,
  input logic        rst_n,
  mdr_fetch_if.slave bus
);

  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]  idx_q;

  logic tmr_clr, tmr_en, tmr_expired;
  logic rd_c, re_c, shift_c, done_c, err_c;

  mdr_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.start) begin
        base_q <= bus.base_addr;
        idx_q  <= '0;
      end else if (state_q == SHIFT) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  // mdr_re follows mem_ack combinationally so the MDR loads on the edge the ack is seen.
  always_comb begin
    state_d = state_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    rd_c    = 1'b0;
    re_c    = 1'b0;
    shift_c = 1'b0;
    done_c  = 1'b0;
    err_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          tmr_clr = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        rd_c = 1'b1;
        re_c = bus.mem_ack;
        if (bus.mem_ack) begin
          state_d = (idx_q == LAST_IDX) ? DONE : SHIFT;
        end else if (tmr_expired) begin
          state_d = ERR;
        end else begin
          tmr_en = 1'b1;
        end
      end
      SHIFT: begin
        shift_c = 1'b1;
        tmr_clr = 1'b1;
        state_d = REQ;
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        err_c   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_rd    = rd_c;
  assign bus.mem_addr  = rd_c ? (base_q + ADDR_W'(idx_q)) : '0;
  assign bus.mdr_re    = re_c;
  assign bus.mdr_shift = shift_c;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_c;
  assign bus.err       = err_c;

endmodule

// File: tb/tb_mdr_fetch_ctrl.sv
// Directed bench for mdr_fetch_ctrl: per-cycle expected trace built from the fetch rules,
// an MDR model fed by the strobes, and literal latency/address/data checks.
module tb_mdr_fetch_ctrl;

  localparam int NB  = 2;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mdr_fetch_if #(.ADDR_W(8)) bus ();

  mdr_fetch_ctrl #(
    .ADDR_W (8),
    .NBYTES (NB),
    .TIMEOUT(TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    bit         start;
    logic [7:0] base;
    bit         ack;
    logic [7:0] data;
    bit         rd;
    logic [7:0] addr;
    bit         re, sh, busy, done, err;
  } ent_t;

  ent_t q[$];
  int total = 0;
  int bad = 0;

  int         plan_wait[NB];
  logic [7:0] plan_data[NB];

  logic [14:0] mdr;
  logic [7:0]  addr_log[$];
  int cyc = 0, start_cyc = -1, ev_cyc = -1;
  int re_cnt, sh_cnt, done_cnt, err_cnt, busy_cnt;

  task automatic push(input bit st, input logic [7:0] b, input bit ack, input logic [7:0] d,
                      input bit rd, input logic [7:0] a, input bit re, input bit sh,
                      input bit busy, input bit dn, input bit er);
    ent_t e;
    e.start = st; e.base = b; e.ack = ack; e.data = d;
    e.rd = rd; e.addr = a; e.re = re; e.sh = sh; e.busy = busy; e.done = dn; e.err = er;
    q.push_back(e);
  endtask

  // Expected cycle sequence of one fetch: start cycle, then per byte the wait cycles,
  // the ack cycle, a shift between bytes, and finally DONE (or ERR on timeout).
  task automatic build_fetch(input logic [7:0] base, input bit start_busy);
    logic [7:0] junk;
    logic [7:0] a;
    junk = start_busy ? 8'h77 : (base ^ 8'h5A);
    push(1'b1, base, 1'b0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0);
    for (int b = 0; b < NB; b++) begin
      a = base + 8'(b);
      if (plan_wait[b] >= TMO) begin
        for (int k = 0; k < TMO; k++) push(start_busy, junk, 1'b0, 8'h00, 1, a, 0, 0, 1, 0, 0);
        push(start_busy, junk, 1'b1, 8'hEE, 0, 8'h00, 0, 0, 1, 0, 1);
        return;
      end
      for (int k = 0; k < plan_wait[b]; k++) push(start_busy, junk, 1'b0, 8'h00, 1, a, 0, 0, 1, 0, 0);
      push(start_busy, junk, 1'b1, plan_data[b], 1, a, 1, 0, 1, 0, 0);
      if (b < NB - 1) push(start_busy, junk, 1'b1, 8'hEE, 0, 8'h00, 0, 1, 1, 0, 0);
    end
    push(start_busy, junk, 1'b1, 8'hEE, 0, 8'h00, 0, 0, 1, 1, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 8'hC3, 1'b1, 8'hEE, 0, 8'h00, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic clear_stats();
    addr_log.delete();
    re_cnt = 0; sh_cnt = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0;
    start_cyc = -1; ev_cyc = -1; mdr = '0;
  endtask

  // Drive inputs on the falling edge, compare just after, apply MDR strobes on the rising edge.
  task automatic run_trace(input int n);
    ent_t e;
    logic [5:0] act, exp;
    logic s_re, s_sh;
    int cnt = 0;
    while (q.size() > 0 && (n < 0 || cnt < n)) begin
      e = q.pop_front();
      cnt++;
      @(negedge clk);
      bus.start = e.start; bus.base_addr = e.base; bus.mem_ack = e.ack;
      #1;
      act = {bus.mem_rd, bus.mdr_re, bus.mdr_shift, bus.busy, bus.done, bus.err};
      exp = {e.rd, e.re, e.sh, e.busy, e.done, e.err};
      total++;
      if (act !== exp || (e.rd && bus.mem_addr !== e.addr)) begin
        bad++;
        $display("FAIL cycle%0d rd/re/sh/busy/done/err got=%b want=%b addr got=%h want=%h",
                 cyc, act, exp, bus.mem_addr, e.addr);
      end
      if (e.start && !e.busy) start_cyc = cyc;
      if (bus.done || bus.err) ev_cyc = cyc;
      if (bus.mdr_re) addr_log.push_back(bus.mem_addr);
      re_cnt += int'(bus.mdr_re); sh_cnt += int'(bus.mdr_shift);
      done_cnt += int'(bus.done); err_cnt += int'(bus.err); busy_cnt += int'(bus.busy);
      s_re = bus.mdr_re; s_sh = bus.mdr_shift;
      @(posedge clk);
      if (s_sh) mdr = {mdr[6:0], 8'h00};
      else if (s_re) mdr[7:0] = e.data;
      cyc++;
    end
  endtask

  function automatic int outs_now();
    return int'({bus.mem_rd, bus.mdr_re, bus.mdr_shift, bus.busy, bus.done, bus.err, bus.mem_addr});
  endfunction

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.base_addr = 8'h00; bus.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("reset_outputs", outs_now(), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // zero-wait fetch from 0x10
    clear_stats();
    plan_wait = '{0, 0}; plan_data = '{8'hA5, 8'h3C};
    build_fetch(8'h10, 1'b0); idle(2); run_trace(-1);
    chk("zw_latency", ev_cyc - start_cyc, 4);
    chk("zw_busy_cycles", busy_cnt, 4);
    chk("zw_nreads", addr_log.size(), 2);
    if (addr_log.size() == 2) begin
      chk("zw_addr0", int'(addr_log[0]), 'h10);
      chk("zw_addr1", int'(addr_log[1]), 'h11);
    end
    chk("zw_mdr", int'(mdr), 'h253C);

    // three wait cycles per byte
    clear_stats();
    plan_wait = '{3, 3}; plan_data = '{8'h5A, 8'hC3};
    build_fetch(8'h20, 1'b0); idle(1); run_trace(-1);
    chk("ws_latency", ev_cyc - start_cyc, 10);
    chk("ws_re_count", re_cnt, 2);
    chk("ws_mdr", int'(mdr), 'h5AC3);

    // memory never acknowledges
    clear_stats();
    plan_wait = '{100, 0}; plan_data = '{8'h00, 8'h00};
    build_fetch(8'h30, 1'b0); idle(2); run_trace(-1);
    chk("to_latency", ev_cyc - start_cyc, 16);
    chk("to_err_count", err_cnt, 1);
    chk("to_done_count", done_cnt, 0);
    chk("to_strobes", re_cnt + sh_cnt, 0);

    // address wrap at top of space
    clear_stats();
    plan_wait = '{1, 0}; plan_data = '{8'h81, 8'h7E};
    build_fetch(8'hFF, 1'b0); idle(1); run_trace(-1);
    chk("wrap_nreads", addr_log.size(), 2);
    if (addr_log.size() == 2) begin
      chk("wrap_addr0", int'(addr_log[0]), 'hFF);
      chk("wrap_addr1", int'(addr_log[1]), 'h00);
    end
    chk("wrap_mdr", int'(mdr), 'h017E);

    // start held while busy and on DONE is ignored; start right after DONE is taken
    clear_stats();
    plan_wait = '{0, 1}; plan_data = '{8'h12, 8'h34};
    build_fetch(8'h40, 1'b1);
    plan_wait = '{0, 0}; plan_data = '{8'h56, 8'h78};
    build_fetch(8'h50, 1'b0); idle(2); run_trace(-1);
    chk("bs_done_count", done_cnt, 2);
    chk("bs_nreads", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      chk("bs_addr2", int'(addr_log[2]), 'h50);
      chk("bs_addr3", int'(addr_log[3]), 'h51);
    end

    // asynchronous reset during SHIFT, then a fresh fetch
    clear_stats();
    plan_wait = '{0, 0}; plan_data = '{8'h99, 8'h88};
    build_fetch(8'h20, 1'b0); run_trace(2);
    q.delete();
    @(negedge clk);
    bus.start = 1'b0; bus.mem_ack = 1'b0;
    #1 chk("pre_rst_shift", int'(bus.mdr_shift), 1);
    rst_n = 1'b0;
    #1 chk("rst_async_outputs", outs_now(), 0);
    @(negedge clk);
    #1 chk("rst_held_outputs", outs_now(), 0);
    rst_n = 1'b1;
    cyc++; cyc++;
    clear_stats();
    plan_wait = '{0, 2}; plan_data = '{8'h11, 8'h22};
    build_fetch(8'h30, 1'b0); idle(2); run_trace(-1);
    chk("rr_latency", ev_cyc - start_cyc, 6);
    chk("rr_nreads", addr_log.size(), 2);
    if (addr_log.size() == 2) begin
      chk("rr_addr0", int'(addr_log[0]), 'h30);
      chk("rr_addr1", int'(addr_log[1]), 'h31);
    end
    chk("rr_mdr", int'(mdr), 'h1122);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdr_fetch_ctrl.md
Name: mdr_fetch_ctrl

Overview:
Sequencer that fills the 15-bit memory data register from byte-wide memory. It issues NBYTES consecutive byte reads starting at a base address, and strobes the MDR's load (re) and shift controls in the required order. The first byte lands in the most-significant position. It sits between the CPU control unit (start/done/err) and the memory/MDR pair. A wait-timeout guards against memory that never acknowledges.

Parameters:
ADDR_W, 8, width of memory address
NBYTES, 2, bytes fetched per word (1..4)
TIMEOUT, 15, max cycles waiting for mem_ack in one request before abort (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a word fetch; sampled only in IDLE
base_addr  in  ADDR_W  address of first byte; latched when start accepted
mem_ack  in  1  memory data valid on MDR in1 this cycle
mem_rd  out  1  read request to memory
mem_addr  out  ADDR_W  byte address of current read
mdr_re  out  1  MDR load strobe (drives MDR re)
mdr_shift  out  1  MDR shift strobe (drives MDR shift)
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse, word complete
err  out  1  one-cycle pulse, timeout abort

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (async): state=IDLE, byte index=0, address register=0, wait counter=0. All outputs are 0, including mem_addr.
- Reset mid-fetch aborts immediately. No done or err pulse is produced. MDR contents are left undefined for the caller.
- States: IDLE, REQ, SHIFT, DONE, ERR.
- IDLE:
  - start=1: latch base_addr, clear index and wait counter, go to REQ.
  - start=0: stay in IDLE.
- REQ:
  - mem_rd=1; mem_addr = latched base + index, modulo 2^ADDR_W (wraps at top of address space).
  - mdr_re = mem_ack (Mealy), so the MDR captures in1 on the same edge the ack is seen.
  - On ack: if index==NBYTES-1, go to DONE; else go to SHIFT.
  - Without ack: increment the wait counter. When it reaches TIMEOUT-1 with no ack, go to ERR.
- SHIFT: mdr_shift=1 for exactly one cycle; index+1; wait counter cleared; go to REQ.
- DONE: done=1 for one cycle; go to IDLE.
- ERR: err=1 for one cycle; go to IDLE. No further MDR strobes.
- mdr_re and mdr_shift are never high in the same cycle. They are never high outside REQ and SHIFT respectively.
- mem_ack outside REQ is ignored.
- start outside IDLE is ignored, including in DONE and ERR; no queuing.
- Latency with zero-wait memory (ack in the first REQ cycle): done asserts 2*NBYTES cycles after the start edge. For NBYTES=2: REQ, SHIFT, REQ, DONE, so done arrives 4 cycles after start is sampled.
- Each memory wait cycle adds 1 cycle of latency.
- Width rule: the MDR holds 15 bits, so for NBYTES=2 bit 7 of the first byte is discarded by the shift. The controller does not compensate.
- Index width is ceil(log2(NBYTES)), minimum 1. Wait counter width is ceil(log2(TIMEOUT+1)).

Decomposition:
- Shared package: state encoding constants (IDLE=0, REQ=1, SHIFT=2, DONE=3, ERR=4, 3-bit) and default values for ADDR_W/NBYTES/TIMEOUT.
- One sub-module is natural: mdr_wait_timer, a loadable down-counter with clear, enable and expired output, used for the timeout.
- FSM, address register and index counter stay in mdr_fetch_ctrl.

Test Plan:
- Zero-wait fetch, base_addr=8'h10, memory returns 8'hA5 then 8'h3C. Expected:
  - mem_addr is 10 then 11; strobe order re, shift, re.
  - MDR = 15'h253C; done 4 cycles after start; busy high for those 4 cycles.
- Wait states: ack delayed 3 cycles on each byte. Expected: done at cycle 10; exactly one mdr_re per byte; mem_rd held throughout each wait.
- Timeout: TIMEOUT=15, mem_ack held 0. Expected: err pulses 16 cycles after start, then IDLE; no mdr_re or mdr_shift at any point; done never asserts.
- Address wrap: base_addr=8'hFF. Expected: mem_addr sequence FF then 00.
- start re-asserted while busy and on the DONE cycle: no second fetch begins. A start one cycle after done is accepted.
- rst_n pulled low during SHIFT: all outputs 0 asynchronously; after release in IDLE, a new start fetches correctly from its new base.
